// File: rtl/pdp8_tape_pkg.sv
// rtl/pdp8_tape_pkg.sv - shared frame constants and encodings for the BIN tape loader
package pdp8_tape_pkg;

    localparam logic [7:0] LEADER     = 8'h80;
    localparam logic [7:0] RUBOUT     = 8'hFF;
    localparam logic [7:0] FIELD_MASK = 8'hC7;
    localparam logic [7:0] FIELD_CODE = 8'hC0;

    typedef enum logic [2:0] {
        SEEK,
        LEAD,
        HI,
        LO,
        CHECK,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        CLS_RUBOUT,
        CLS_LEADER,
        CLS_FIELD,
        CLS_ORIGIN,
        CLS_DATA
    } frame_cls_t;

endpackage

// File: rtl/bin_frame_decode.sv
// rtl/bin_frame_decode.sv - combinational classifier of one BIN tape frame
module bin_frame_decode
    import pdp8_tape_pkg::*;
#(
    parameter logic [7:0] LEADER_CODE = LEADER
) (
    input  logic [7:0] frame,
    output frame_cls_t cls,
    output logic [5:0] payload,
    output logic       low_ok
);

    always_comb begin
        cls = CLS_DATA;
        if (frame == RUBOUT)
            cls = CLS_RUBOUT;
        else if (frame == LEADER_CODE)
            cls = CLS_LEADER;
        else if ((frame & FIELD_MASK) == FIELD_CODE)
            cls = CLS_FIELD;
        else if (frame[6])
            cls = CLS_ORIGIN;
    end

    assign payload = frame[5:0];
    assign low_ok  = (frame[7:6] == 2'b00);

endmodule

// File: rtl/bin_tape_loader.sv
// rtl/bin_tape_loader.sv - PDP-8 BIN paper-tape loader writing 12-bit words into RAM
// Optional field-setting frames enabled by defining BIN_FIELD_EN.
module bin_tape_loader #(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] LEADER = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:7]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [0:ADDR_W-1] wr_addr,
    output logic [0:11]       wr_data,
    output logic              wr_en,
`ifdef BIN_FIELD_EN
    output logic [0:2]        wr_field,
`endif
    output logic              busy,
    output logic              done,
    output logic              err
);
    import pdp8_tape_pkg::*;

    logic [7:0]        b;
    frame_cls_t        cls;
    logic [5:0]        payload;
    logic              low_ok;
    state_t            state_q, state_d;
    logic              accept, take_hi, word_done, set_err;
    logic [7:0]        hi_q;
    logic              hi_org;
    logic              pend_vld, pend_org;
    logic [11:0]       pend_word;
    logic [8:0]        pend_sum;
    logic [11:0]       cksum;
    logic [ADDR_W-1:0] addr;
`ifdef BIN_FIELD_EN
    logic              field_set;
`endif

    assign b          = byte_in;
    assign accept     = byte_valid & byte_ready;
    assign done       = (state_q == FIN);
    assign byte_ready = !done;
    assign busy       = (state_q == LEAD) || (state_q == HI) || (state_q == LO);

    bin_frame_decode #(.LEADER_CODE(LEADER)) u_decode (
        .frame   (b),
        .cls     (cls),
        .payload (payload),
        .low_ok  (low_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= SEEK;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        take_hi   = 1'b0;
        word_done = 1'b0;
        set_err   = 1'b0;
`ifdef BIN_FIELD_EN
        field_set = 1'b0;
`endif
        if (accept && cls != CLS_RUBOUT) begin
            case (state_q)
                SEEK: if (cls == CLS_LEADER) state_d = LEAD;
                LEAD, HI: begin
                    case (cls)
                        CLS_LEADER: if (state_q == HI) state_d = CHECK;
                        CLS_ORIGIN, CLS_DATA: begin
                            take_hi = 1'b1;
                            state_d = LO;
                        end
`ifdef BIN_FIELD_EN
                        CLS_FIELD: field_set = 1'b1;
`endif
                        default: ;
                    endcase
                end
                LO: begin
                    if (low_ok) begin
                        word_done = 1'b1;
                        state_d   = HI;
                    end else begin
                        set_err = 1'b1;
                        state_d = FIN;
                    end
                end
                default: ;
            endcase
        end
        // The word still pending at the trailer is the checksum itself.
        if (state_q == CHECK) begin
            state_d = FIN;
            if (!pend_vld || pend_org || pend_word != cksum)
                set_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= 8'h00;
            hi_org    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_org  <= 1'b0;
            pend_word <= 12'h000;
            pend_sum  <= 9'h000;
            cksum     <= 12'h000;
            addr      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 12'h000;
            err       <= 1'b0;
`ifdef BIN_FIELD_EN
            wr_field  <= 3'b000;
`endif
        end else begin
            wr_en <= 1'b0;
            if (take_hi) begin
                hi_q   <= b;
                hi_org <= (cls == CLS_ORIGIN);
            end
            if (word_done) begin
                if (pend_vld) begin
                    cksum <= cksum + 12'(pend_sum);
                    if (pend_org) begin
                        addr <= ADDR_W'(pend_word);
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= pend_word;
                        addr    <= addr + ADDR_W'(1);
                    end
                end
                pend_vld  <= 1'b1;
                pend_org  <= hi_org;
                pend_word <= {hi_q[5:0], payload};
                pend_sum  <= 9'(hi_q) + 9'(b);
            end
            if (set_err)
                err <= 1'b1;
`ifdef BIN_FIELD_EN
            if (field_set)
                wr_field <= b[5:3];
`endif
        end
    end

endmodule

// File: tb/tb_bin_tape_loader.sv
// tb/tb_bin_tape_loader.sv - self-checking bench for bin_tape_loader
module tb_bin_tape_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en, busy, done, err;
    logic [11:0] wr_addr, wr_data;
`ifdef BIN_FIELD_EN
    logic [2:0]  wr_field;
`endif

    bin_tape_loader dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
`ifdef BIN_FIELD_EN
        .wr_field   (wr_field),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        wen;
        logic [11:0] a;
        logic [11:0] d;
        logic        bsy;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t        vt[11];
    int          tests = 0;
    int          fails = 0;
    int          rub_wr;
    logic [11:0] cap_a[$];
    logic [11:0] cap_d[$];
    logic [7:0]  tape[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en) begin
            cap_a.push_back(wr_addr);
            cap_d.push_back(wr_data);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ready"}, byte_ready, 1);
    endtask

    task automatic pulse_reset(input string tag);
        byte_valid = 1'b0;
        reset = 1'b0;
        #2;
        check_reset(tag);
        reset = 1'b1;
    endtask

    task automatic feed(input bit toggle);
        cap_a.delete();
        cap_d.delete();
        rub_wr = 0;
        foreach (tape[i]) begin
            if (toggle) begin
                byte_in = 8'hC1;
                byte_valid = 1'b0;
                tick();
            end
            byte_in = tape[i];
            byte_valid = 1'b1;
            tick();
            if (tape[i] == 8'hFF && wr_en) rub_wr++;
        end
        byte_valid = 1'b0;
        byte_in = 8'h00;
    endtask

    task automatic run_tape(input string tag, input bit toggle);
        int n;
        feed(toggle);
        n = 0;
        while (!done && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ready_low"}, byte_ready, 0);
    endtask

    task automatic chk_write(input string tag, input int k, input logic [11:0] a, input logic [11:0] d);
        if (cap_a.size() > k) begin
            chk({tag, "_addr"}, cap_a[k], a);
            chk({tag, "_data"}, cap_d[k], d);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s_missing: got %0d writes expected more than %0d", tag, cap_a.size(), k);
        end
    endtask

    initial begin
        vt[0]  = '{8'h80, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{8'h80, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{8'h80, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{8'h42, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{8'h00, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{8'h3C, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{8'h02, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{8'h02, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{8'h00, 1'b1, 1'b1, 12'h080, 12'hF02, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{8'h80, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{8'h00, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0};

        #3;
        check_reset("por");
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            byte_in = vt[i].b;
            byte_valid = vt[i].v;
            tick();
            chk($sformatf("vec%0d_wr_en", i), wr_en, vt[i].wen);
            if (vt[i].wen) begin
                chk($sformatf("vec%0d_wr_addr", i), wr_addr, vt[i].a);
                chk($sformatf("vec%0d_wr_data", i), wr_data, vt[i].d);
            end
            chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
            chk($sformatf("vec%0d_done", i), done, vt[i].dn);
            chk($sformatf("vec%0d_err", i), err, vt[i].er);
        end
        chk("good_ready_low", byte_ready, 0);
        pulse_reset("rst_after_good");

        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h01, 8'h80};
        run_tape("badsum", 1'b0);
        chk("badsum_nwr", cap_a.size(), 1);
        chk_write("badsum_w0", 0, 12'h080, 12'hF02);
        chk("badsum_err", err, 1);
        pulse_reset("rst_after_bad");

        tape = '{8'h80, 8'h7F, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03, 8'h01, 8'h80};
        run_tape("wrap", 1'b0);
        chk("wrap_nwr", cap_a.size(), 2);
        chk_write("wrap_w0", 0, 12'hFFF, 12'h001);
        chk_write("wrap_w1", 1, 12'h000, 12'h002);
        chk("wrap_err", err, 0);
        pulse_reset("rst_after_wrap");

        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'hFF, 8'h00, 8'h3C, 8'hFF, 8'h02,
                 8'h02, 8'hFF, 8'h00, 8'h80};
        run_tape("hshake", 1'b1);
        chk("hshake_nwr", cap_a.size(), 1);
        chk_write("hshake_w0", 0, 12'h080, 12'hF02);
        chk("hshake_rubout_wr", rub_wr, 0);
        chk("hshake_err", err, 0);
        pulse_reset("rst_after_hshake");

        tape = '{8'h80, 8'h80, 8'hD0, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h00, 8'h80};
        run_tape("field", 1'b0);
        chk("field_nwr", cap_a.size(), 1);
        chk_write("field_w0", 0, 12'h080, 12'hF02);
        chk("field_err", err, 0);
`ifdef BIN_FIELD_EN
        chk("field_value", wr_field, 3'd2);
`endif
        pulse_reset("rst_after_field");

        tape = '{8'h80, 8'h42, 8'h00, 8'h80};
        run_tape("orgpend", 1'b0);
        chk("orgpend_nwr", cap_a.size(), 0);
        chk("orgpend_err", err, 1);
        pulse_reset("rst_after_orgpend");

        tape = '{8'h80, 8'h42, 8'hC0};
        run_tape("field_in_lo", 1'b0);
        chk("field_in_lo_err", err, 1);
        pulse_reset("rst_after_filo");

        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C};
        feed(1'b0);
        chk("midword_busy", busy, 1);
        pulse_reset("rst_midword");
        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h00, 8'h80};
        run_tape("reload", 1'b0);
        chk("reload_nwr", cap_a.size(), 1);
        chk_write("reload_w0", 0, 12'h080, 12'hF02);
        chk("reload_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
